carry_lookahead_adder_4_bit: RTL and testbench

//   4-bit carry-lookahead adder with registered 5-bit result (carry-out in MSB).
//   All carries computed in parallel from generate/propagate terms; no ripple.

---
 rtl/cla_pkg.sv | 45 ++++
 rtl/cla_lookahead_unit_4.sv | 28 ++
 rtl/carry_lookahead_adder_4_bit.sv | 97 +++++++++
 tb/tb_carry_lookahead_adder_4_bit.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/cla_pkg.sv
// Shared carry-lookahead helpers.
//
// Holds the slice width and the two-level carry function so that this 4-bit
// leaf and any higher lookahead level compute carries identically.
//
// Contents:
//   CLA_WIDTH     - slice width (4)
//   cla_carries   - p, g, cin -> c[4:0], every carry as a flat AND-OR term
//   cla_group_p   - group propagate (all bits propagate)
//   cla_group_g   - group generate (a carry leaves the slice without cin)
package cla_pkg;

  localparam int CLA_WIDTH = 4;

  // Every carry is written out in full from p/g/cin. No carry is built from
  // an earlier one, so all four settle after one AND-OR level.
  function automatic logic [CLA_WIDTH:0] cla_carries(
    input logic [CLA_WIDTH-1:0] p,
    input logic [CLA_WIDTH-1:0] g,
    input logic                 cin
  );
    logic [CLA_WIDTH:0] c;
    c[0] = cin;
    c[1] = g[0] | (p[0] & cin);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
         | (p[2] & p[1] & p[0] & cin);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
         | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & cin);
    return c;
  endfunction

  function automatic logic cla_group_p(input logic [CLA_WIDTH-1:0] p);
    return p[3] & p[2] & p[1] & p[0];
  endfunction

  function automatic logic cla_group_g(
    input logic [CLA_WIDTH-1:0] p,
    input logic [CLA_WIDTH-1:0] g
  );
    return g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
         | (p[3] & p[2] & p[1] & g[0]);
  endfunction

endpackage

// File: rtl/cla_lookahead_unit_4.sv
// Combinational 4-bit lookahead unit.
//
// Ports:
//   p_i       [3:0] in   per-bit propagate (a ^ b)
//   g_i       [3:0] in   per-bit generate  (a & b)
//   cin_i           in   carry into bit 0
//   c_o       [4:1] out  carries into bits 1..3 plus carry-out (c_o[4])
//   group_p_o       out  slice propagates cin straight through
//   group_g_o       out  slice produces a carry-out by itself
module cla_lookahead_unit_4
  import cla_pkg::*;
(
  input  logic [CLA_WIDTH-1:0] p_i,
  input  logic [CLA_WIDTH-1:0] g_i,
  input  logic                 cin_i,
  output logic [CLA_WIDTH:1]   c_o,
  output logic                 group_p_o,
  output logic                 group_g_o
);

  // c[0] just echoes cin_i back; the caller already has it.
  logic c0_unused_s;

  assign {c_o, c0_unused_s} = cla_carries(p_i, g_i, cin_i);
  assign group_p_o          = cla_group_p(p_i);
  assign group_g_o          = cla_group_g(p_i, g_i);

endmodule

// File: rtl/carry_lookahead_adder_4_bit.sv
// 4-bit carry-lookahead adder with a registered 5-bit result.
//
// The result appears one clock after the inputs are sampled. It is the
// unsigned sum A + B + cin, with the carry-out in sum_o[4].
//
// Optional feature: define CLA_GROUP_PG_EN to add the registered group
// propagate/generate outputs that feed a second-level lookahead unit.
//
// Ports:
//   clk_i             in   clock, rising edge
//   rst_ni            in   asynchronous active-low reset
//   number_1_i  [3:0] in   addend A (unsigned)
//   number_2_i  [3:0] in   addend B (unsigned)
//   carry_i_i         in   carry-in
//   sum_o       [4:0] out  registered A+B+cin, sum_o[4] = carry-out
//   group_p_o         out  registered group propagate (CLA_GROUP_PG_EN)
//   group_g_o         out  registered group generate  (CLA_GROUP_PG_EN)
module carry_lookahead_adder_4_bit
  import cla_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [CLA_WIDTH-1:0] number_1_i,
  input  logic [CLA_WIDTH-1:0] number_2_i,
  input  logic                 carry_i_i,
`ifdef CLA_GROUP_PG_EN
  output logic [CLA_WIDTH:0]   sum_o,
  output logic                 group_p_o,
  output logic                 group_g_o
`else
  output logic [CLA_WIDTH:0]   sum_o
`endif
);

  localparam int WIDTH = CLA_WIDTH;

  logic [WIDTH-1:0] p_s;
  logic [WIDTH-1:0] g_s;
  logic [WIDTH:0]   c_s;
  logic             grp_p_s;
  logic             grp_g_s;
  logic [WIDTH:0]   sum_d;
  logic [WIDTH:0]   sum_q;

  assign p_s    = number_1_i ^ number_2_i;
  assign g_s    = number_1_i & number_2_i;
  assign c_s[0] = carry_i_i;

  cla_lookahead_unit_4 u_lookahead (
    .p_i       (p_s),
    .g_i       (g_s),
    .cin_i     (carry_i_i),
    .c_o       (c_s[WIDTH:1]),
    .group_p_o (grp_p_s),
    .group_g_o (grp_g_s)
  );

  // Sum bits: each bit is its propagate term XOR its incoming carry.
  always_comb begin
    sum_d = {c_s[WIDTH], p_s ^ c_s[WIDTH-1:0]};
  end

  // Result register. It loads on every clock and clears at once on reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sum_q <= 5'b00000;
    end else begin
      sum_q <= sum_d;
    end
  end

  assign sum_o = sum_q;

`ifdef CLA_GROUP_PG_EN
  logic grp_p_q;
  logic grp_g_q;

  // Group P/G register. It has the same timing and reset as the sum.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      grp_p_q <= 1'b0;
      grp_g_q <= 1'b0;
    end else begin
      grp_p_q <= grp_p_s;
      grp_g_q <= grp_g_s;
    end
  end

  assign group_p_o = grp_p_q;
  assign group_g_o = grp_g_q;
`else
  // Group terms are only exported when the second-level feature is built.
  logic grp_unused_s;
  assign grp_unused_s = grp_p_s ^ grp_g_s;
`endif

endmodule

// File: tb/tb_carry_lookahead_adder_4_bit.sv
module tb_carry_lookahead_adder_4_bit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] a;
  logic [3:0] b;
  logic       cin;
  logic [4:0] sum;
`ifdef CLA_GROUP_PG_EN
  logic       gp;
  logic       gg;
`endif

  always #5 clk = ~clk;

  carry_lookahead_adder_4_bit dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .number_1_i (a),
    .number_2_i (b),
    .carry_i_i  (cin),
`ifdef CLA_GROUP_PG_EN
    .sum_o      (sum),
    .group_p_o  (gp),
    .group_g_o  (gg)
`else
    .sum_o      (sum)
`endif
  );

  int checks = 0;
  int passes = 0;
  bit cmp_en = 1'b0;

  task automatic chk(input string nm, input logic [4:0] act, input logic [4:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %b expected %b (t=%0t)", nm, act, exp, $time);
  endtask

  // Reference model: plain integer addition, updated one clock later, cleared by reset.
  logic [4:0] model_sum;
  logic       model_gp;
  logic       model_gg;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      model_sum <= 5'd0;
      model_gp  <= 1'b0;
      model_gg  <= 1'b0;
    end else begin
      model_sum <= 5'({1'b0, a} + {1'b0, b} + {4'b0, cin});
      model_gp  <= ((a ^ b) == 4'hF);
      model_gg  <= (({1'b0, a} + {1'b0, b}) > 5'd15);
    end
  end

  // Compare process: check on every falling edge.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("model_sum", sum, model_sum);
`ifdef CLA_GROUP_PG_EN
      chk("model_gp", {4'b0, gp}, {4'b0, model_gp});
      chk("model_gg", {4'b0, gg}, {4'b0, model_gg});
`endif
    end
  end

  typedef struct {
    logic [3:0] va;
    logic [3:0] vb;
    logic       vc;
    logic [4:0] ve;
  } vec_t;

  vec_t vecs[10] = '{
    '{4'b0011, 4'b0000, 1'b0, 5'b00011},
    '{4'b0001, 4'b0001, 1'b0, 5'b00010},
    '{4'b1111, 4'b0001, 1'b0, 5'b10000},
    '{4'b1111, 4'b1111, 1'b0, 5'b11110},
    '{4'b1000, 4'b1111, 1'b0, 5'b10111},
    '{4'b0000, 4'b0111, 1'b1, 5'b01000},
    '{4'b1111, 4'b1111, 1'b1, 5'b11111},
    '{4'b0000, 4'b0000, 1'b1, 5'b00001},
    '{4'b0001, 4'b0001, 1'b1, 5'b00011},
    '{4'b1010, 4'b0101, 1'b1, 5'b10000}
  };

  initial begin
    rst_n = 1'b0;
    a = 4'hF; b = 4'hF; cin = 1'b1;
    #1 cmp_en = 1'b1;

    // Reset held through clock edges with all-ones inputs.
    repeat (2) @(posedge clk);
    #1 chk("reset_held", sum, 5'b00000);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1 chk("first_capture", sum, 5'b11111);
    // Asynchronous assert mid-cycle, with no clock edge.
    #1 rst_n = 1'b0;
    #1 chk("async_reset", sum, 5'b00000);
    @(posedge clk);
    #2 rst_n = 1'b1;

    // Directed vectors, one at a time.
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #2 a = vecs[i].va; b = vecs[i].vb; cin = vecs[i].vc;
      @(posedge clk);
      #1 chk($sformatf("vec%0d", i), sum, vecs[i].ve);
    end

    // Back-to-back stream: every result appears exactly one edge later.
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1 if (i > 0) chk($sformatf("stream%0d", i - 1), sum, vecs[i - 1].ve);
      #1 a = vecs[i].va; b = vecs[i].vb; cin = vecs[i].vc;
      #1 if (i > 0) chk($sformatf("hold%0d", i - 1), sum, vecs[i - 1].ve);
    end
    @(posedge clk);
    #1 chk("stream9", sum, vecs[9].ve);

    // Reset in the middle of the run clears the output at once.
    #1 rst_n = 1'b0;
    #1 chk("midrun_reset", sum, 5'b00000);
    @(posedge clk);
    #1 chk("midrun_reset_held", sum, 5'b00000);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1 chk("after_reset", sum, vecs[9].ve);

`ifdef CLA_GROUP_PG_EN
    #1 a = 4'b1010; b = 4'b0101; cin = 1'b0;
    @(posedge clk);
    #1 chk("gp_prop", {4'b0, gp}, 5'd1);
    chk("gg_prop", {4'b0, gg}, 5'd0);
    #1 a = 4'b1000; b = 4'b1000; cin = 1'b0;
    @(posedge clk);
    #1 chk("gp_gen", {4'b0, gp}, 5'd0);
    chk("gg_gen", {4'b0, gg}, 5'd1);
`endif

    // Exhaustive sweep of all 512 inputs; the model checker judges each one.
    for (int i = 0; i < 512; i++) begin
      @(posedge clk);
      #2 {a, b, cin} = 9'(i);
    end
    repeat (2) @(posedge clk);
    #1 chk("sweep_last", sum, 5'b11111);

    @(negedge clk);
    #1 cmp_en = 1'b0;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
